// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// A single full_adder cell is reused once per clock. A carry flip-flop links
// each bit position to the next one. The start/busy/done handshake lets the
// surrounding datapath sequence operations.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input. With sub=1
// the block computes op_a - op_b by loading ~op_b with an initial carry of 1.

// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a_reg;
  logic [WIDTH-1:0] sh_b_reg;
  logic [WIDTH-1:0] sh_s_reg;
  logic             carry_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic [WIDTH-1:0] sum_shifted;

  // Operand B and the initial carry as they are loaded on the accepting edge.
`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is two's complement: invert B bit by bit and force the carry to 1.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
      assign b_load[gi] = op_b[gi] ^ sub;
    end
  endgenerate
  assign cin_load = sub | cin;
`else
  assign b_load   = op_b;
  assign cin_load = cin;
`endif

  // The shared arithmetic cell always sees the current LSBs and the carry flop.
  full_adder u_fa (
    .a    (sh_a_reg[0]),
    .b    (sh_b_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit    = (bit_cnt_reg == CW'(WIDTH - 1));
  assign sum_shifted = {fa_sum, sh_s_reg[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so requests are never queued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: the operands are loaded on accept and shifted one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a_reg    <= '0;
      sh_b_reg    <= '0;
      sh_s_reg    <= '0;
      carry_reg   <= 1'b0;
      bit_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sh_a_reg    <= op_a;
            sh_b_reg    <= b_load;
            carry_reg   <= cin_load;
            bit_cnt_reg <= '0;
          end
        end
        RUN: begin
          sh_s_reg    <= sum_shifted;
          sh_a_reg    <= {1'b0, sh_a_reg[WIDTH-1:1]};
          sh_b_reg    <= {1'b0, sh_b_reg[WIDTH-1:1]};
          carry_reg   <= fa_cout;
          bit_cnt_reg <= bit_cnt_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result and carry-out are updated only on the edge that enters DONE, so
  // partial sums are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else if (state_reg == RUN && last_bit) begin
      result_reg <= sum_shifted;
      cout_reg   <= fa_cout;
    end
  end

  // busy and done are registered copies of the upcoming state, which keeps
  // the outputs free of combinational paths from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= (state_next == RUN);
      done_reg <= (state_next == DONE);
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign cout   = cout_reg;

endmodule
